cic_comp_fir: RTL

CIC_COMP_FIR -- requirements
Module: cic_comp_fir

---
 rtl/cic_comp_fir_if.sv | 21 ++
 rtl/cic_comp_fir.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cic_comp_fir_if.sv
// Valid/ready sample stream into and out of the CIC compensation FIR.
interface cic_comp_fir_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_ready;

  modport master (
    output in_valid, output in_data, input in_ready,
    input out_valid, input out_data, output out_ready
  );

  modport slave (
    input in_valid, input in_data, output in_ready,
    output out_valid, output out_data, input out_ready
  );
endinterface

// File: rtl/cic_comp_fir.sv
// 8-tap CIC droop compensation FIR, one serial MAC, one sample per 10 clocks.
// Define CIC_COMP_FIR_SAT_EN to saturate the output instead of wrapping it.
module cic_comp_fir #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_TAPS   = 8,
  parameter int unsigned COEF_FRAC  = 5
) (
  input  logic          clk,
  input  logic          reset,
  cic_comp_fir_if.slave bus
);

  localparam int unsigned ACC_W  = 36;
  localparam int unsigned COEF_W = 6;
  localparam int unsigned PROD_W = DATA_WIDTH + COEF_W;
  localparam int unsigned IDX_W  = $clog2(NUM_TAPS);

  localparam logic signed [ACC_W-1:0] RND = ACC_W'(2 ** (COEF_FRAC - 1));
`ifdef CIC_COMP_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] taps_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] taps_d [NUM_TAPS];
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                         accept_c;
  logic                         last_tap_c;
  logic signed [PROD_W-1:0]     prod_c;
  logic signed [ACC_W-1:0]      acc_sum_c;

  // Symmetric coefficients, sum 32 = unity DC gain with COEF_FRAC = 5.
  function automatic logic signed [COEF_W-1:0] coef(input logic [IDX_W-1:0] idx);
    logic signed [COEF_W-1:0] c;
    case (idx)
      IDX_W'(0), IDX_W'(7): c = COEF_W'(-1);
      IDX_W'(1), IDX_W'(6): c = COEF_W'(2);
      IDX_W'(2), IDX_W'(5): c = COEF_W'(-4);
      default:              c = COEF_W'(19);
    endcase
    return c;
  endfunction

  // Round half up, drop fraction bits, then clamp or wrap to the sample width.
  function automatic logic signed [DATA_WIDTH-1:0] scale(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = (acc + RND) >>> COEF_FRAC;
`ifdef CIC_COMP_FIR_SAT_EN
    if (shifted > SAT_MAX) begin
      shifted = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      shifted = SAT_MIN;
    end
`endif
    return DATA_WIDTH'(shifted);
  endfunction

  assign accept_c   = (state_q == ST_IDLE) && in_ready_q && bus.in_valid;
  assign last_tap_c = (idx_q == IDX_W'(NUM_TAPS - 1));
  assign prod_c     = PROD_W'(taps_q[idx_q]) * PROD_W'(coef(idx_q));
  assign acc_sum_c  = acc_q + ACC_W'(prod_c);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept_c)       state_d = ST_MAC;
      ST_MAC:  if (last_tap_c)     state_d = ST_OUT;
      ST_OUT:  if (bus.out_ready)  state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    taps_d      = taps_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          taps_d[0] = bus.in_data;
          for (int unsigned i = 1; i < NUM_TAPS; i++) begin
            taps_d[i] = taps_q[i-1];
          end
          acc_d = '0;
          idx_d = '0;
        end
      end
      ST_MAC: begin
        acc_d = acc_sum_c;
        idx_d = idx_q + IDX_W'(1);
        // Final tap: publish the result on the same edge that enters OUT.
        if (last_tap_c) begin
          out_valid_d = 1'b1;
          out_data_d  = scale(acc_sum_c);
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        taps_q[i] <= '0;
      end
      acc_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      taps_q      <= taps_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
